// File: rtl/psg_stereo_pkg.sv
// Shared definitions for the stereo PSG: register map, noise rates and
// the attenuation-to-level table.
package psg_stereo_pkg;

  // Register addressed by the latch byte bits [6:4].
  typedef enum logic [2:0] {
    REG_T1_FREQ     = 3'd0,
    REG_T1_ATTEN    = 3'd1,
    REG_T2_FREQ     = 3'd2,
    REG_T2_ATTEN    = 3'd3,
    REG_T3_FREQ     = 3'd4,
    REG_T3_ATTEN    = 3'd5,
    REG_NOISE_CTRL  = 3'd6,
    REG_NOISE_ATTEN = 3'd7
  } psg_reg_e;

  // Noise rate selector values (noise ctrl bits [1:0]).
  localparam logic [1:0] NOISE_RATE_16 = 2'd0;
  localparam logic [1:0] NOISE_RATE_32 = 2'd1;
  localparam logic [1:0] NOISE_RATE_64 = 2'd2;
  localparam logic [1:0] NOISE_RATE_T3 = 2'd3;

  // Attenuation (0 = loudest, 15 = off) to 10-bit level.
  function automatic logic [9:0] vol_lut(input logic [3:0] atten);
    logic [9:0] lvl;
    case (atten)
      4'd0:    lvl = 10'd1023;
      4'd1:    lvl = 10'd813;
      4'd2:    lvl = 10'd646;
      4'd3:    lvl = 10'd513;
      4'd4:    lvl = 10'd407;
      4'd5:    lvl = 10'd323;
      4'd6:    lvl = 10'd257;
      4'd7:    lvl = 10'd205;
      4'd8:    lvl = 10'd162;
      4'd9:    lvl = 10'd128;
      4'd10:   lvl = 10'd102;
      4'd11:   lvl = 10'd81;
      4'd12:   lvl = 10'd64;
      4'd13:   lvl = 10'd51;
      4'd14:   lvl = 10'd40;
      default: lvl = 10'd0;
    endcase
    return lvl;
  endfunction

  // Reload value of the noise counter for a given rate selector.
  function automatic logic [9:0] noise_period(input logic [1:0] rate,
                                              input logic [9:0] t3_freq);
    logic [9:0] per;
    case (rate)
      NOISE_RATE_16: per = 10'h010;
      NOISE_RATE_32: per = 10'h020;
      NOISE_RATE_64: per = 10'h040;
      default:       per = t3_freq;
    endcase
    return per;
  endfunction

endpackage

// File: rtl/psg_stereo_tone_gen.sv
// One PSG period counter: 10-bit down counter with a toggling output.
// reload pulses on the tick where the counter wraps, which the noise
// channel uses as its shift strobe.
module psg_tone_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] freq,
  output logic       out,
  output logic       reload
);

  logic [9:0] count;

  assign reload = tick && (count == 10'd0);

  // Count down per tick; on wrap reload from freq and flip the output.
  // freq 0 and 1 both reload to 0 so that either toggles every tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 10'd0;
      out   <= 1'b0;
    end else if (tick) begin
      if (count == 10'd0) begin
        count <= (freq <= 10'd1) ? 10'd0 : freq;
        out   <= ~out;
      end else begin
        count <= count - 10'd1;
      end
    end
  end

endmodule

// File: rtl/psg_stereo.sv
// SN76489-compatible PSG with Game Gear stereo panning: three tone
// channels, one LFSR noise channel, left/right 16-bit mixes.
module psg_stereo
  import psg_stereo_pkg::*;
#(
  parameter int                CLK_DIV       = 256,
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] NOISE_SEED    = 16'h4000,
  parameter logic [LFSR_W-1:0] NOISE_MASK    = 16'hF037,
  parameter logic [LFSR_W-1:0] PERIODIC_MASK = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  wrdata,
  input  logic        wren,
  input  logic        stereo_wren,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_valid
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [9:0]        freq [3];
  logic [3:0]        atten [4];
  logic [2:0]        noise_ctrl;
  logic [2:0]        latch_idx;
  logic [7:0]        stereo;
  logic [2:0]        wr_idx;
  logic              noise_ctrl_wr;
  logic [LFSR_W-1:0] lfsr;
  logic              noise_out;
  logic [9:0]        noise_freq;
  logic              noise_reload;
  logic              noise_tog_unused;
  logic [2:0]        tone_out;
  logic [2:0]        tone_reload_unused;
  logic [3:0]        chan_on;
  logic [11:0]       mix_l;
  logic [11:0]       mix_r;
  logic              vld_p0;

  assign tick          = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign wr_idx        = wrdata[7] ? wrdata[6:4] : latch_idx;
  assign noise_ctrl_wr = wren && (wr_idx == REG_NOISE_CTRL);
  assign noise_freq    = noise_period(noise_ctrl[1:0], freq[2]);
  assign chan_on       = {noise_out, tone_out};

  // Generator tick divider: counts 0..CLK_DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Write decoder for the latch/data byte protocol and the stereo register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) freq[i] <= 10'd0;
      for (int i = 0; i < 4; i++) atten[i] <= 4'hF;
      noise_ctrl <= 3'd0;
      latch_idx  <= 3'd0;
      stereo     <= 8'hFF;
    end else begin
      if (stereo_wren) stereo <= wrdata;
      if (wren) begin
        if (wrdata[7]) latch_idx <= wrdata[6:4];
        case (wr_idx)
          REG_T1_FREQ, REG_T2_FREQ, REG_T3_FREQ: begin
            if (wrdata[7]) freq[wr_idx[2:1]][3:0] <= wrdata[3:0];
            else           freq[wr_idx[2:1]][9:4] <= wrdata[5:0];
          end
          REG_T1_ATTEN, REG_T2_ATTEN, REG_T3_ATTEN, REG_NOISE_ATTEN:
            atten[wr_idx[2:1]] <= wrdata[3:0];
          REG_NOISE_CTRL:
            noise_ctrl <= wrdata[2:0];
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_tone
    psg_tone_gen u_tone (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .freq   (freq[g]),
      .out    (tone_out[g]),
      .reload (tone_reload_unused[g])
    );
  end

  psg_tone_gen u_noise_cnt (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .freq   (noise_freq),
    .out    (noise_tog_unused),
    .reload (noise_reload)
  );

  // Noise LFSR: shifts on each noise counter reload; a ctrl write reseeds
  // it and wins over a shift landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= NOISE_SEED;
      noise_out <= 1'b0;
    end else begin
      if (noise_reload) begin
        noise_out <= lfsr[0];
        lfsr      <= (lfsr >> 1) ^
                     (lfsr[0] ? (noise_ctrl[2] ? NOISE_MASK : PERIODIC_MASK)
                              : '0);
      end
      if (noise_ctrl_wr) lfsr <= NOISE_SEED;
    end
  end

  // Per-side sum of enabled channel levels (bit order: T1, T2, T3, noise).
  always_comb begin
    mix_l = 12'd0;
    mix_r = 12'd0;
    for (int i = 0; i < 4; i++) begin
      if (chan_on[i] && stereo[i + 4]) mix_l = mix_l + {2'b00, vol_lut(atten[i])};
      if (chan_on[i] && stereo[i])     mix_r = mix_r + {2'b00, vol_lut(atten[i])};
    end
  end

  // Stage p0: tick delayed one edge so the mix sees the updated outputs.
  // Stage p1: registered mix and valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0       <= 1'b0;
      sample_valid <= 1'b0;
      sample_l     <= 16'd0;
      sample_r     <= 16'd0;
    end else begin
      vld_p0       <= tick;
      sample_valid <= vld_p0;
      if (vld_p0) begin
        sample_l <= {mix_l, 4'b0000};
        sample_r <= {mix_r, 4'b0000};
      end
    end
  end

endmodule

// File: tb/tb_psg_stereo.sv
// Randomized self-checking bench for psg_stereo against a tick-level
// behavioural model of the PSG.
module tb_psg_stereo;

  localparam int CLK_DIV = 16;
  localparam int SEED    = 'h4000;
  localparam int NMASK   = 'hF037;
  localparam int PMASK   = 'h8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wrdata;
  logic        wren;
  logic        stereo_wren;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;

  always #5 clk = ~clk;

  psg_stereo #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .wrdata       (wrdata),
    .wren         (wren),
    .stereo_wren  (stereo_wren),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int lut [16] = '{1023, 813, 646, 513, 407, 323, 257, 205,
                   162, 128, 102, 81, 64, 51, 40, 0};
  int m_div, m_ctrl, m_latch, m_stereo, m_lfsr, m_vld, m_l, m_r, m_valid;
  int m_freq [3];
  int m_att  [4];
  int m_left [4];   // ticks left until the channel's next toggle/shift
  int m_out  [4];

  task automatic model_reset();
    m_div = 0; m_ctrl = 0; m_latch = 0; m_stereo = 'hFF; m_lfsr = SEED;
    m_vld = 0; m_l = 0; m_r = 0; m_valid = 0;
    for (int i = 0; i < 3; i++) m_freq[i] = 0;
    for (int i = 0; i < 4; i++) begin
      m_att[i] = 15; m_left[i] = 1; m_out[i] = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int tick, per, l, r, idx, d;
    if (reset) begin
      model_reset();
      return;
    end
    tick = (m_div == CLK_DIV - 1);
    if (m_vld) begin
      l = 0; r = 0;
      for (int i = 0; i < 4; i++)
        if (m_out[i] != 0) begin
          if ((m_stereo >> (i + 4)) & 1) l += lut[m_att[i]];
          if ((m_stereo >> i) & 1)       r += lut[m_att[i]];
        end
      m_l = l * 16;
      m_r = r * 16;
    end
    m_valid = m_vld;
    m_vld   = tick;
    m_div   = tick ? 0 : m_div + 1;
    if (tick) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (ch < 3)                 per = m_freq[ch];
        else if ((m_ctrl & 3) == 3) per = m_freq[2];
        else                        per = 16 << (m_ctrl & 3);
        m_left[ch]--;
        if (m_left[ch] == 0) begin
          m_left[ch] = (per <= 1) ? 1 : per + 1;
          if (ch < 3) m_out[ch] ^= 1;
          else begin
            m_out[3] = m_lfsr & 1;
            m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr & 1) ? ((m_ctrl & 4) ? NMASK : PMASK) : 0);
          end
        end
      end
    end
    if (stereo_wren) m_stereo = wrdata;
    if (wren) begin
      d   = wrdata;
      idx = (d & 'h80) ? ((d >> 4) & 7) : m_latch;
      if (d & 'h80) m_latch = (d >> 4) & 7;
      if (idx == 6) begin
        m_ctrl = d & 7;
        m_lfsr = SEED;
      end else if (idx % 2 == 1) begin
        m_att[idx / 2] = d & 15;
      end else if (d & 'h80) begin
        m_freq[idx / 2] = (m_freq[idx / 2] & 'h3F0) | (d & 15);
      end else begin
        m_freq[idx / 2] = (m_freq[idx / 2] & 15) | ((d & 63) << 4);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int ncyc = 0;
  int last_vld = -1;
  int max_l = 0;
  int max_r = 0;
  bit seen_l [int];

  task automatic step(input bit rst, input bit w, input bit sw, input logic [7:0] d);
    @(negedge clk);
    reset = rst; wren = w; stereo_wren = sw; wrdata = d;
    model_step();
    @(posedge clk);
    #1;
    ncyc++;
    check_val("valid", sample_valid, m_valid);
    check_val("left",  sample_l, m_l);
    check_val("right", sample_r, m_r);
    if (rst) last_vld = -1;
    if (sample_valid === 1'b1) begin
      if (last_vld >= 0) check_val("valid_period", ncyc - last_vld, CLK_DIV);
      last_vld = ncyc;
      if (sample_l > max_l) max_l = sample_l;
      if (sample_r > max_r) max_r = sample_r;
      seen_l[int'(sample_l)] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic psg_wr(input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic stereo_wr(input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic clear_seen();
    max_l = 0; max_r = 0; seen_l.delete();
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; stereo_wren = 1'b0; wrdata = 8'h00;
    model_reset();

    // Reset state
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_val("rst_l", sample_l, 0);
    check_val("rst_r", sample_r, 0);
    check_val("rst_valid", sample_valid, 0);
    idle(4 * CLK_DIV);

    // Tone period: T1 freq 0x05E at full volume
    psg_wr(8'h8E); psg_wr(8'h05); psg_wr(8'h90);
    clear_seen();
    idle(3 * 96 * CLK_DIV);
    check_val("tone_max_l", max_l, 16368);
    check_val("tone_max_r", max_r, 16368);
    check_val("tone_zero_seen", seen_l.exists(0), 1);

    // Data byte to T2 attenuation
    psg_wr(8'hB0); psg_wr(8'h07);
    clear_seen();
    idle(200 * CLK_DIV);
    check_val("t2_atten_seen", seen_l.exists(3280), 1);

    // Stereo panning of T1, T2 muted
    psg_wr(8'hBF);
    stereo_wr(8'h1F);
    clear_seen();
    idle(200 * CLK_DIV);
    check_val("pan_both_r", max_r, 16368);
    stereo_wr(8'h10);
    idle(2 * CLK_DIV);
    clear_seen();
    idle(200 * CLK_DIV);
    check_val("pan_left_l", max_l, 16368);
    check_val("pan_left_r", max_r, 0);

    // Noise: white, rate 0x10, full volume, tones muted
    psg_wr(8'h9F); stereo_wr(8'hFF);
    psg_wr(8'hE4); psg_wr(8'hF0);
    clear_seen();
    idle(400 * CLK_DIV);
    check_val("noise_active", max_l, 16368);
    psg_wr(8'hE4);
    idle(200 * CLK_DIV);
    psg_wr(8'hE0);                      // periodic
    idle(100 * CLK_DIV);

    // Rate 3 with T3 freq 0: noise shifts every tick
    psg_wr(8'hC0); psg_wr(8'h00);
    psg_wr(8'hE7);
    idle(200 * CLK_DIV);

    // Write coinciding with a tick edge
    for (int k = 0; k < 8; k++) begin
      idle(CLK_DIV - 1 - ((ncyc + k) % CLK_DIV));
      psg_wr(8'hE4 | 8'(k & 3));
    end

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 60)       psg_wr(8'($urandom));
      else if (r < 70)  stereo_wr(8'($urandom));
      else if (r < 73)  step(1'b0, 1'b1, 1'b1, 8'($urandom));
      else if (r < 75)  step(1'b1, 1'b0, 1'b0, 8'h00);
      else              idle(1);
    end

    // Reset mid-tone
    psg_wr(8'h90); psg_wr(8'h83); psg_wr(8'h00);
    idle(20 * CLK_DIV);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_val("midrst_l", sample_l, 0);
    check_val("midrst_r", sample_r, 0);
    check_val("midrst_valid", sample_valid, 0);
    idle(3 * CLK_DIV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
